// File: rtl/ram_frame_ctrl.sv
// ram_frame_ctrl: captures a frame of ADC samples into an external dual-port RAM,
// then streams the frame back out through a Dout_valid/Dout_ready port.
// Build option: define FRAME_CTRL_MISS_CNT_EN to add the Trig_miss_cnt output, which
// counts Trig requests that arrive while the controller is busy.
module ram_frame_ctrl #(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 14
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Trig,
    input  logic [RAM_ADDR_BITS:0]   Frame_len,
    input  logic [RAM_WIDTH-1:0]     Din,
    input  logic                     Din_valid,
    output logic                     Wr_en,
    output logic [RAM_ADDR_BITS-1:0] Wr_Addr,
    output logic [RAM_WIDTH-1:0]     Wr_data,
    output logic                     Rd_en,
    output logic [RAM_ADDR_BITS-1:0] Rd_Addr,
    input  logic [RAM_WIDTH-1:0]     Rd_data,
    output logic [RAM_WIDTH-1:0]     Dout,
    output logic                     Dout_valid,
    input  logic                     Dout_ready,
    output logic                     Busy,
    output logic                     Frame_done
`ifdef FRAME_CTRL_MISS_CNT_EN
    ,
    output logic [15:0]              Trig_miss_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StCapture, StReadout} state_e;

    localparam logic [RAM_ADDR_BITS:0] MaxLen = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam logic [RAM_ADDR_BITS:0] CntOne = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS:0]   len_q;
    logic [RAM_ADDR_BITS:0]   wr_cnt_q;   // words written so far
    logic [RAM_ADDR_BITS:0]   rd_cnt_q;   // RAM reads issued so far
    logic [RAM_ADDR_BITS:0]   out_cnt_q;  // words accepted downstream so far
    logic                     rd_pend_q;  // a read was issued last cycle; Rd_data is live now
    logic [RAM_WIDTH-1:0]     dout_q, skid_q;
    logic                     dout_valid_q, skid_valid_q;

    logic       trig_ok, wr_fire, wr_last, accept, done_fire;
    logic [1:0] occ, occ_after;

    // Decode of trigger legality, write/accept events and pipeline occupancy
    always_comb begin
        trig_ok   = Trig && (Frame_len != '0) && (Frame_len <= MaxLen);
        wr_fire   = (state_q == StCapture) && Din_valid;
        wr_last   = wr_fire && ((wr_cnt_q + CntOne) == len_q);
        accept    = dout_valid_q && Dout_ready;
        done_fire = (state_q == StReadout) && accept && ((out_cnt_q + CntOne) == len_q);
        // Words held or in flight; a new read is safe only if, after this cycle's
        // accept, fewer than two slots (output reg + skid) are spoken for.
        occ       = {1'b0, dout_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
        occ_after = occ - {1'b0, accept};
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (trig_ok)   state_d = StCapture;
            StCapture: if (wr_last)   state_d = StReadout;
            StReadout: if (done_fire) state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    // FSM outputs and RAM port drive
    always_comb begin
        Busy       = (state_q != StIdle);
        Wr_en      = wr_fire;
        Wr_Addr    = wr_cnt_q[RAM_ADDR_BITS-1:0];
        Wr_data    = Din;
        Rd_en      = (state_q == StReadout) && (rd_cnt_q < len_q) && (occ_after < 2'd2);
        Rd_Addr    = rd_cnt_q[RAM_ADDR_BITS-1:0];
        Dout       = dout_q;
        Dout_valid = dout_valid_q;
        Frame_done = done_fire;
    end

    // Frame length latch and address/word counters
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            len_q     <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (state_q == StIdle && trig_ok) begin
                len_q     <= Frame_len;
                wr_cnt_q  <= '0;
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (wr_fire) wr_cnt_q  <= wr_cnt_q + CntOne;
                if (Rd_en)   rd_cnt_q  <= rd_cnt_q + CntOne;
                if (accept)  out_cnt_q <= out_cnt_q + CntOne;
            end
        end
    end

    // Readout pipeline: returning RAM word goes to the output register, or to the
    // skid buffer when the output register is stalled; skid always drains first.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_pend_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            rd_pend_q <= Rd_en;
            if (!dout_valid_q || accept) begin
                if (skid_valid_q) begin
                    dout_q       <= skid_q;
                    dout_valid_q <= 1'b1;
                    skid_valid_q <= rd_pend_q;
                    if (rd_pend_q) skid_q <= Rd_data;
                end else if (rd_pend_q) begin
                    dout_q       <= Rd_data;
                    dout_valid_q <= 1'b1;
                end else begin
                    dout_valid_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_q       <= Rd_data;
                skid_valid_q <= 1'b1;
            end
        end
    end

`ifdef FRAME_CTRL_MISS_CNT_EN
    logic [15:0] miss_cnt_q;

    // Saturating count of triggers dropped while busy
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            miss_cnt_q <= '0;
        end else if (Trig && Busy && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign Trig_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ram_frame_ctrl.sv
// tb_ram_frame_ctrl: directed bench for ram_frame_ctrl with a behavioural dual-port
// RAM attached; built with RAM_ADDR_BITS=4 so a full-depth frame is 16 words.
module tb_ram_frame_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          wr_en, rd_en, dout_valid, busy, frame_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, dout;
    logic [DW-1:0] rd_data = '0;
    logic          dout_ready = 1'b0;
`ifdef FRAME_CTRL_MISS_CNT_EN
    logic [15:0]   trig_miss_cnt;
`endif

    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_frame_ctrl #(
        .RAM_WIDTH    (DW),
        .RAM_ADDR_BITS(AW)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .Trig         (trig),
        .Frame_len    (frame_len),
        .Din          (din),
        .Din_valid    (din_valid),
        .Wr_en        (wr_en),
        .Wr_Addr      (wr_addr),
        .Wr_data      (wr_data),
        .Rd_en        (rd_en),
        .Rd_Addr      (rd_addr),
        .Rd_data      (rd_data),
        .Dout         (dout),
        .Dout_valid   (dout_valid),
        .Dout_ready   (dout_ready),
        .Busy         (busy),
        .Frame_done   (frame_done)
`ifdef FRAME_CTRL_MISS_CNT_EN
        ,
        .Trig_miss_cnt(trig_miss_cnt)
`endif
    );

    // External RAM: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW:0] len);
        trig      = 1'b1;
        frame_len = len;
        tick();
        trig      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, wr_en, rd_en, dout_valid, frame_done, dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {busy, wr_en, rd_en, dout_valid, frame_done, dout});
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
        tick();
    endtask

    task automatic test_basic();
        start_frame(5'd4);
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h10 + 8'(i);
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'(i) || wr_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL basic_write%0d got en=%b a=%h d=%h exp en=1 a=%h d=%h",
                         i, wr_en, wr_addr, wr_data, 4'(i), 8'h10 + 8'(i));
            end
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        // Readout cycles 0..5: valid from cycle 2, done on cycle 5; Trig on done is ignored
        for (int c = 0; c < 6; c++) begin
            if (c == 5) trig = 1'b1;
            @(negedge clk);
            checks++;
            if (dout_valid !== (c >= 2) || rd_en !== (c < 4) || frame_done !== (c == 5)) begin
                errors++;
                $display("FAIL basic_ctl%0d got v=%b rd=%b fd=%b exp v=%b rd=%b fd=%b", c,
                         dout_valid, rd_en, frame_done, c >= 2, c < 4, c == 5);
            end
            if (c >= 2) begin
                checks++;
                if (dout !== 8'h10 + 8'(c - 2)) begin
                    errors++;
                    $display("FAIL basic_dout%0d got %h exp %h", c, dout, 8'h10 + 8'(c - 2));
                end
            end
            tick();
        end
        trig = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got busy=%b v=%b fd=%b exp 0 0 0",
                     busy, dout_valid, frame_done);
        end
        tick();
    endtask

    task automatic test_gapped();
        int  writes = 0;
        int  k = 0;
        bit  done = 0;
        start_frame(5'd8);
        for (int c = 0; c < 15; c++) begin
            din_valid = (c % 2 == 0);
            din       = 8'h40 + 8'(c);
            trig      = (c == 3 || c == 4);  // ignored while busy
            frame_len = 5'd3;
            @(negedge clk);
            checks++;
            if (wr_en !== din_valid || rd_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL gap_cap%0d got en=%b rd=%b busy=%b exp en=%b rd=0 busy=1",
                         c, wr_en, rd_en, busy, din_valid);
            end
            if (wr_en) begin
                checks++;
                if (wr_addr !== 4'(writes)) begin
                    errors++;
                    $display("FAIL gap_addr got %h exp %h", wr_addr, 4'(writes));
                end
                writes++;
            end
            tick();
        end
        trig       = 1'b0;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b1 || writes != 8) begin
            errors++;
            $display("FAIL gap_readout got en=%b rd=%b writes=%0d exp en=0 rd=1 writes=8",
                     wr_en, rd_en, writes);
        end
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== (dout_valid && dout_ready && k == 7)) begin
                errors++;
                $display("FAIL gap_done got %b at word %0d", frame_done, k);
            end
            if (dout_valid) begin
                checks++;
                if (dout !== 8'h40 + 8'(2 * k)) begin
                    errors++;
                    $display("FAIL gap_dout%0d got %h exp %h", k, dout, 8'h40 + 8'(2 * k));
                end
                if (k == 7) done = 1;
                k++;
            end
            tick();
        end
        checks++;
        if (!done || busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_finish got words=%0d busy=%b exp words=8 busy=0", k, busy);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp_w [6];
        logic [DW-1:0] prev_dout = '0;
        bit            prev_stall = 0;
        bit            done = 0;
        int            k = 0;
        exp_w = '{8'h5A, 8'hC3, 8'h01, 8'hFE, 8'h77, 8'h80};
        start_frame(5'd6);
        din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = exp_w[i];
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'($urandom_range(0, 1));
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== prev_dout) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h",
                             dout_valid, dout, prev_dout);
                end
            end
            checks++;
            if (frame_done !== (dout_valid && dout_ready && k == 5)) begin
                errors++;
                $display("FAIL stall_done got %b at word %0d", frame_done, k);
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (dout !== exp_w[k]) begin
                    errors++;
                    $display("FAIL stall_dout%0d got %h exp %h", k, dout, exp_w[k]);
                end
                if (k == 5) done = 1;
                k++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            tick();
            dout_ready = 1'($urandom_range(0, 1));
        end
        dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (!done || dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_finish got words=%0d v=%b busy=%b exp words=6 v=0 busy=0",
                     k, dout_valid, busy);
        end
        tick();
    endtask

    task automatic test_full();
        bit done = 0;
        int k = 0;
        start_frame(5'd16);
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'hA5 ^ 8'(i * 7);
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'(i)) begin
                errors++;
                $display("FAIL full_write%0d got en=%b a=%h exp en=1 a=%h",
                         i, wr_en, wr_addr, 4'(i));
            end
            tick();
        end
        dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL full_no_wrap got en=%b exp 0", wr_en);
        end
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                checks++;
                if (dout !== (8'hA5 ^ 8'(k * 7)) || frame_done !== (k == 15)) begin
                    errors++;
                    $display("FAIL full_dout%0d got d=%h fd=%b exp d=%h fd=%b", k, dout,
                             frame_done, 8'hA5 ^ 8'(k * 7), k == 15);
                end
                if (k == 15) done = 1;
                k++;
            end
            tick();
        end
        checks++;
        if (!done || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_finish got words=%0d busy=%b exp words=16 busy=0", k, busy);
        end
        start_frame(5'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_ignored busy got %b exp 0", busy);
        end
        tick();
        start_frame(5'd17);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL len17_ignored busy got %b exp 0", busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bit done = 0;
        start_frame(5'd8);
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'hB0 + 8'(i);
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (dout_valid) k++;
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, wr_en, rd_en, dout_valid, frame_done, dout, wr_addr, rd_addr} !== '0
            || k != 3) begin
            errors++;
            $display("FAIL midreset_outputs got %h words=%0d exp 0 words=3",
                     {busy, wr_en, rd_en, dout_valid, frame_done, dout, wr_addr, rd_addr}, k);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle%0d got busy=%b rd=%b v=%b exp 0 0 0",
                         c, busy, rd_en, dout_valid);
            end
            tick();
        end
        start_frame(5'd2);
        din_valid = 1'b1;
        din = 8'hD1;
        tick();
        din = 8'hD2;
        tick();
        din_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                checks++;
                if (dout !== 8'hD1 + 8'(k) || frame_done !== (k == 1)) begin
                    errors++;
                    $display("FAIL refill_dout%0d got d=%h fd=%b exp d=%h fd=%b",
                             k, dout, frame_done, 8'hD1 + 8'(k), k == 1);
                end
                if (k == 1) done = 1;
                k++;
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (!done || busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL refill_finish got words=%0d busy=%b v=%b exp words=2 busy=0 v=0",
                     k, busy, dout_valid);
        end
        tick();
    endtask

`ifdef FRAME_CTRL_MISS_CNT_EN
    task automatic test_miss_cnt();
        start_frame(5'd4);
        din_valid = 1'b0;
        trig = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        trig = 1'b0;
        @(negedge clk);
        checks++;
        if (trig_miss_cnt !== 16'd5) begin
            errors++;
            $display("FAIL miss_cnt got %0d exp 5", trig_miss_cnt);
        end
        tick();
        din_valid = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_stall();
        test_full();
        test_reset_mid();
`ifdef FRAME_CTRL_MISS_CNT_EN
        test_miss_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
